// File: rtl/gpio_in_capture_pkg.sv
// gpio_in_capture_pkg: shared widths and limits for the gpio input capture block
package gpio_in_capture_pkg;
  localparam int GPIO_WIDTH = 8;
  localparam int SYNC_STAGES_MIN = 2;
  typedef logic [GPIO_WIDTH-1:0] gpio_vec_t;
endpackage

// File: rtl/gpio_in_capture_if.sv
// gpio_in_capture_if: pin, event-control and status signals between register bank and capture block
interface gpio_in_capture_if
  import gpio_in_capture_pkg::*;
#(
  parameter int WIDTH = GPIO_WIDTH
);
  logic [WIDTH-1:0] gpio_i;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] irq_mask;
  logic             clr_valid;
  logic [WIDTH-1:0] clr_bits;
  logic [WIDTH-1:0] data_o;
  logic [WIDTH-1:0] status_o;
  logic             irq_o;
  modport master (
    output gpio_i, rise_en, fall_en, irq_mask, clr_valid, clr_bits,
    input  data_o, status_o, irq_o
  );
  modport slave (
    input  gpio_i, rise_en, fall_en, irq_mask, clr_valid, clr_bits,
    output data_o, status_o, irq_o
  );
endinterface

// File: rtl/gpio_in_capture_debounce.sv
// gpio_debounce_bit: synchronizes one pin, accepts a new level after DB_CYCLES stable cycles, pulses on edges
module gpio_debounce_bit
  import gpio_in_capture_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int STAGES = SYNC_STAGES < SYNC_STAGES_MIN ? SYNC_STAGES_MIN : SYNC_STAGES;
  localparam int CW = $clog2(DB_CYCLES + 1);
  logic [STAGES-1:0] sync;
  logic [CW-1:0]     cnt;
  logic              sync_q;
  logic              flip;
  assign sync_q = sync[STAGES-1];
  assign flip   = (sync_q != level) && (cnt == CW'(DB_CYCLES - 1));
  assign rise   = flip & sync_q;
  assign fall   = flip & ~sync_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync  <= {sync[STAGES-2:0], pin};
      cnt   <= (sync_q == level || flip) ? '0 : cnt + 1'b1;
      level <= flip ? sync_q : level;
    end
  end
endmodule

// File: rtl/gpio_in_capture.sv
// gpio_in_capture: debounced gpio inputs with sticky edge status, write-1-to-clear and maskable irq
module gpio_in_capture
  import gpio_in_capture_pkg::*;
#(
  parameter int WIDTH       = GPIO_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input logic              clk,
  input logic              rst_n,
  gpio_in_capture_if.slave io
);
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] status;
  logic             irq;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_debounce_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES)
    ) u_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .pin  (io.gpio_i[i]),
      .level(data[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end
  // new events are ORed in after the clear so a same-cycle set always survives
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status <= '0;
      irq    <= 1'b0;
    end else begin
      status <= (status & ~(io.clr_valid ? io.clr_bits : '0)) | (rise & io.rise_en) | (fall & io.fall_en);
      irq    <= |(status & io.irq_mask);
    end
  end
  assign io.data_o   = data;
  assign io.status_o = status;
  assign io.irq_o    = irq;
endmodule
